// File: rtl/sram_port_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of a single-port SRAM macro, with optional bounded lock bursts.
// Build option: define SRAM_ARB_RSP_REG_EN to register read responses (2-cycle read latency instead of 1).
module sram_port_arbiter #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 64,
    parameter int WMASK_WIDTH = 2,
    parameter int MAX_LOCK    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic                   a_we,
    input  logic [WMASK_WIDTH-1:0] a_wmask,
    input  logic [ADDR_WIDTH-1:0]  a_addr,
    input  logic [DATA_WIDTH-1:0]  a_din,
    input  logic                   a_lock,
    output logic                   a_rvalid,
    output logic [DATA_WIDTH-1:0]  a_rdata,
    input  logic                   b_valid,
    output logic                   b_ready,
    input  logic                   b_we,
    input  logic [WMASK_WIDTH-1:0] b_wmask,
    input  logic [ADDR_WIDTH-1:0]  b_addr,
    input  logic [DATA_WIDTH-1:0]  b_din,
    input  logic                   b_lock,
    output logic                   b_rvalid,
    output logic [DATA_WIDTH-1:0]  b_rdata,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOCK_A = 2'd1;
    localparam logic [1:0] ST_LOCK_B = 2'd2;

    logic [1:0]       state, state_nxt;
    logic             prio, prio_nxt;   // 0 = A, 1 = B
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             grant_a, grant_b, granted, g_port, g_lock, g_we;
    logic             owner_b, own_valid, own_lock;
    logic             tag_valid, tag_port;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    if (a_valid && (!b_valid || !prio)) grant_a = 1'b1;
                    else if (b_valid)                   grant_b = 1'b1;
                end
                ST_LOCK_A: grant_a = a_valid;
                ST_LOCK_B: grant_b = b_valid;
                default: ;
            endcase
        end
    end

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign granted   = grant_a | grant_b;
    assign g_port    = grant_b;
    assign g_lock    = grant_b ? b_lock : a_lock;
    assign g_we      = grant_b ? b_we : a_we;
    assign owner_b   = (state == ST_LOCK_B);
    assign own_valid = owner_b ? b_valid : a_valid;
    assign own_lock  = owner_b ? b_lock : a_lock;
    assign cnt_inc   = cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (granted) begin
                    prio_nxt = ~g_port;
                    if (g_lock && (MAX_LOCK > 1)) begin
                        state_nxt = g_port ? ST_LOCK_B : ST_LOCK_A;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            ST_LOCK_A, ST_LOCK_B: begin
                // Release on an unlocked owner transfer, an idle unlocked owner, or a full burst.
                if (granted) begin
                    cnt_nxt = cnt_inc;
                    if (!g_lock || (cnt_inc == CNT_W'(MAX_LOCK))) begin
                        state_nxt = ST_IDLE;
                        prio_nxt  = ~owner_b;
                        cnt_nxt   = '0;
                    end
                end else if (!own_valid && !own_lock) begin
                    state_nxt = ST_IDLE;
                    prio_nxt  = ~owner_b;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            prio      <= 1'b0;
            cnt       <= '0;
            tag_valid <= 1'b0;
            tag_port  <= 1'b0;
        end else begin
            state     <= state_nxt;
            prio      <= prio_nxt;
            cnt       <= cnt_nxt;
            tag_valid <= granted & ~g_we;
            tag_port  <= g_port;
        end
    end

    always_comb begin
        sram_we    = 1'b0;
        sram_wmask = '0;
        sram_addr  = '0;
        sram_din   = '0;
        if (grant_a) begin
            sram_we    = a_we;
            sram_wmask = a_wmask;
            sram_addr  = a_addr;
            sram_din   = a_din;
        end else if (grant_b) begin
            sram_we    = b_we;
            sram_wmask = b_wmask;
            sram_addr  = b_addr;
            sram_din   = b_din;
        end
    end

`ifdef SRAM_ARB_RSP_REG_EN
    logic                  a_rvalid_q, b_rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            a_rvalid_q <= tag_valid & ~tag_port;
            b_rvalid_q <= tag_valid & tag_port;
            rdata_q    <= sram_dout;
        end
    end

    // Masked by rst so a response in flight when reset arrives never shows.
    assign a_rvalid = a_rvalid_q & ~rst;
    assign b_rvalid = b_rvalid_q & ~rst;
    assign a_rdata  = rdata_q;
    assign b_rdata  = rdata_q;
`else
    assign a_rvalid = tag_valid & ~tag_port & ~rst;
    assign b_rvalid = tag_valid & tag_port & ~rst;
    assign a_rdata  = sram_dout;
    assign b_rdata  = sram_dout;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: behavioural SRAM macro, scoreboard of expected read returns, grant checks.
module tb_sram_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 64;
    localparam int MW = 2;
    localparam int ML = 16;
    localparam int EW = 32 + 1 + DW;
`ifdef SRAM_ARB_RSP_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk, rst;
    logic          a_valid, a_ready, a_we, a_lock, a_rvalid;
    logic [MW-1:0] a_wmask;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_din, a_rdata;
    logic          b_valid, b_ready, b_we, b_lock, b_rvalid;
    logic [MW-1:0] b_wmask;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_din, b_rdata;
    logic          sram_we;
    logic [MW-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din, sram_dout;

    logic [DW-1:0] mem [0:1023];
    logic [DW-1:0] ref_mem [0:1023];
    logic [EW-1:0] exp_q[$];
    int cyc = 0;
    int total = 0;
    int bad = 0;

    sram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW), .MAX_LOCK(ML)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_wmask(a_wmask), .a_addr(a_addr),
        .a_din(a_din), .a_lock(a_lock), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_wmask(b_wmask), .b_addr(b_addr),
        .b_din(b_din), .b_lock(b_lock), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_word(input int i);
        logic [31:0] v;
        v = 32'(i);
        return (i >= 16) ? {v, ~v} : '0;
    endfunction

    // Behavioural macro: write at posedge, synchronous read visible the next cycle.
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
        end else if (sram_we) begin
            for (int l = 0; l < MW; l++)
                if (sram_wmask[l]) mem[sram_addr][l*32 +: 32] = sram_din[l*32 +: 32];
        end else begin
            sram_dout <= mem[sram_addr];
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_a(input logic v, input logic we, input logic [MW-1:0] m,
                           input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic lk);
        a_valid = v; a_we = we; a_wmask = m; a_addr = ad; a_din = d; a_lock = lk;
    endtask

    task automatic drive_b(input logic v, input logic we, input logic [MW-1:0] m,
                           input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic lk);
        b_valid = v; b_we = we; b_wmask = m; b_addr = ad; b_din = d; b_lock = lk;
    endtask

    // One cycle: check grants and macro pins, feed the scoreboard, then advance.
    task automatic step(input string name, input logic ea, input logic eb, input bit push = 1'b1);
        logic          gb, we;
        logic [MW-1:0] m;
        logic [AW-1:0] ad;
        logic [DW-1:0] d;
        @(negedge clk);
        chk({name, "_grant"}, {b_ready, a_ready}, {eb, ea});
        if (rst) chk({name, "_rst_rvalid"}, {b_rvalid, a_rvalid}, 2'b00);
        if (a_ready || b_ready) begin
            gb = b_ready;
            we = gb ? b_we : a_we;
            m  = gb ? b_wmask : a_wmask;
            ad = gb ? b_addr : a_addr;
            d  = gb ? b_din : a_din;
            chk({name, "_pins"}, {sram_we, sram_wmask, sram_addr, sram_din}, {we, m, ad, d});
            if (we) begin
                for (int l = 0; l < MW; l++)
                    if (m[l]) ref_mem[ad][l*32 +: 32] = d[l*32 +: 32];
            end else if (push) begin
                exp_q.push_back({32'(cyc + LAT), gb, ref_mem[ad]});
            end
        end else begin
            chk({name, "_idle_pins"}, {sram_we, sram_wmask, sram_addr, sram_din}, '0);
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        chk("ready_onehot", a_ready & b_ready, 1'b0);
        if (a_rvalid || b_rvalid) begin
            chk("rvalid_onehot", a_rvalid & b_rvalid, 1'b0);
            if (exp_q.size() == 0) begin
                chk("unexpected_rvalid", {b_rvalid, a_rvalid}, 2'b00);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_cycle", 32'(cyc), e[EW-1 -: 32]);
                chk("rsp_port", b_rvalid, e[DW]);
                chk("rsp_data", b_rvalid ? b_rdata : a_rdata, e[DW-1:0]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        rst = 1'b1;
        drive_a(1, 0, 2'b00, 10'd1, '0, 0);
        drive_b(1, 0, 2'b00, 10'd2, '0, 0);
        @(posedge clk); #1;
        step("reset", 0, 0);
        step("reset", 0, 0);
        drive_a(0, 0, 0, 0, '0, 0);
        drive_b(0, 0, 0, 0, '0, 0);
        rst = 1'b0;
        step("idle", 0, 0);

        // Full write by A, read back by B.
        drive_a(1, 1, 2'b11, 10'd5, 64'hDEADBEEF_CAFEF00D, 0);
        step("wr5", 1, 0);
        drive_a(0, 0, 0, 0, '0, 0);
        drive_b(1, 0, 2'b00, 10'd5, '0, 0);
        step("rd5", 0, 1);
        drive_b(0, 0, 0, 0, '0, 0);
        repeat (3) step("gap1", 0, 0);

        // Lower-lane-only write, read back the next cycle.
        drive_a(1, 1, 2'b01, 10'd7, 64'h11111111_11111111, 0);
        step("wr7", 1, 0);
        drive_a(1, 0, 2'b00, 10'd7, '0, 0);
        step("rd7", 1, 0);
        drive_a(0, 0, 0, 0, '0, 0);
        repeat (3) step("gap2", 0, 0);

        // Fresh reset so prio starts at A, then contended reads alternate.
        rst = 1'b1;
        step("reset2", 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_a(1, 0, 2'b00, 10'(16 + i), '0, 0);
            drive_b(1, 0, 2'b00, 10'(40 + i), '0, 0);
            step("alt", (i % 2) == 0, (i % 2) == 1);
        end
        drive_a(0, 0, 0, 0, '0, 0);
        drive_b(0, 0, 0, 0, '0, 0);
        repeat (3) step("gap3", 0, 0);

        // Locked burst by A is cut at MAX_LOCK, then B gets in.
        drive_b(1, 0, 2'b00, 10'd60, '0, 0);
        for (int i = 0; i <= ML; i++) begin
            drive_a(1, 1, 2'b11, 10'(100 + i), {$urandom, $urandom}, 1);
            step("burst", i < ML, i == ML);
        end
        drive_a(0, 0, 0, 0, '0, 0);
        drive_b(0, 0, 0, 0, '0, 0);
        repeat (3) step("gap4", 0, 0);

        // Lock held with the owner idle blocks B until released.
        drive_a(1, 1, 2'b11, 10'd200, 64'h0123_4567_89AB_CDEF, 1);
        step("lk_start", 1, 0);
        drive_a(0, 0, 2'b00, 10'd0, '0, 1);
        drive_b(1, 0, 2'b00, 10'd61, '0, 0);
        repeat (3) step("lk_hold", 0, 0);
        drive_a(0, 0, 2'b00, 10'd0, '0, 0);
        step("lk_rel", 0, 0);
        step("lk_b", 0, 1);
        drive_b(1, 0, 2'b00, 10'd200, '0, 0);
        step("rd200", 0, 1);
        drive_b(0, 0, 0, 0, '0, 0);
        repeat (3) step("gap5", 0, 0);

        // Read in flight when reset hits must never return.
        drive_a(1, 0, 2'b00, 10'd16, '0, 0);
        step("rd_pre_rst", 1, 0, 1'b0);
        drive_a(0, 0, 0, 0, '0, 0);
        rst = 1'b1;
        step("reset3", 0, 0);
        step("reset3", 0, 0);
        rst = 1'b0;
        drive_a(1, 0, 2'b00, 10'd20, '0, 0);
        drive_b(1, 0, 2'b00, 10'd21, '0, 0);
        step("post_a", 1, 0);
        step("post_b", 0, 1);
        drive_a(0, 0, 0, 0, '0, 0);
        drive_b(0, 0, 0, 0, '0, 0);
        repeat (4) step("drain", 0, 0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-port request arbiter and sequencer in front of a single-port 1024x64 SRAM22 macro with 32-bit write-mask granularity. It accepts independent valid/ready requests from two requesters (A, B) and grants at most one per cycle using round-robin priority. An optional lock gives one requester an exclusive bounded burst. It drives the macro's we/wmask/addr/din pins and routes the macro's dout back to the requester that issued each read.

## Interface

Parameters:
- ADDR_WIDTH, 10, SRAM word address width
- DATA_WIDTH, 64, SRAM word width
- WMASK_WIDTH, 2, write-mask bits (one per 32-bit lane)
- MAX_LOCK, 16, max accepted transfers per locked burst (>=1)

Ports (p in {a,b}):
- clk  input  1  single clock; shared with the SRAM macro
- rst  input  1  synchronous, active-high reset
- p_valid  input  1  request valid
- p_ready  output  1  request accepted this cycle (grant)
- p_we  input  1  1 = write, 0 = read
- p_wmask  input  WMASK_WIDTH  lane enables for writes; ignored on reads
- p_addr  input  ADDR_WIDTH  word address
- p_din  input  DATA_WIDTH  write data
- p_lock  input  1  request/hold exclusive burst
- p_rvalid  output  1  read data valid pulse (no backpressure)
- p_rdata  output  DATA_WIDTH  read data
- sram_we  output  1  to macro we
- sram_wmask  output  WMASK_WIDTH  to macro wmask
- sram_addr  output  ADDR_WIDTH  to macro addr
- sram_din  output  DATA_WIDTH  to macro din
- sram_dout  input  DATA_WIDTH  from macro dout

## Operation

- Transfer = p_valid & p_ready in a cycle. The grant is combinational from valid, state and priority. At most one of a_ready/b_ready is high.
- Granted cycle: the sram_* pins carry the granted port's we/wmask/addr/din.
- Idle cycle (no grant, or rst high): sram_we=0, sram_wmask=0, sram_addr=0, sram_din=0. The resulting dummy read is discarded.
- Write with wmask=0 is accepted as a no-op. Writes produce no rvalid.
- State: IDLE or LOCKED(owner), plus a priority pointer prio and a lock counter cnt (clog2(MAX_LOCK+1) bits).
- IDLE:
  - Exactly one valid: that port is granted.
  - Both valid: port prio is granted.
  - After any transfer, prio points to the non-granted port.
  - A transfer with p_lock=1 and MAX_LOCK>1 enters LOCKED(p) with cnt=1.
- LOCKED(owner):
  - Only the owner can be granted; the other port's ready=0.
  - Each owner transfer increments cnt.
  - Exit to IDLE, with prio set to the other port, on whichever comes first:
    - an owner transfer with lock=0;
    - a cycle with owner valid=0 and lock=0;
    - the transfer that makes cnt==MAX_LOCK (that transfer is completed).
  - Owner valid=0 with lock=1: hold LOCKED with no grant, and cnt unchanged.
- Read return: a read tag (valid and port id) is registered on each read transfer. When the tag matures, p_rvalid pulses for one cycle on the tagged port only, and p_rdata = sram_dout.
- Back-to-back reads from alternating ports return in issue order, one per cycle.

## Timing

- Read latency (transfer cycle T → rvalid): 1 cycle without the config macro, 2 cycles with it.
- Write: committed at the posedge ending cycle T. A read of the same address at T+1 returns the new data.
- Sustained throughput: 1 transfer per cycle.
- Reset values (rst high at a posedge): state=IDLE, prio=A, cnt=0, tags cleared.
- While rst is high: a_ready=b_ready=0, a_rvalid=b_rvalid=0, sram_* at idle values.
- Any read accepted before reset and not yet returned is dropped; its rvalid never asserts.
- p_rdata is don't-care while p_rvalid=0.

## Configuration

- SRAM_ARB_RSP_REG_EN defined:
  - p_rdata and p_rvalid are driven from output registers loaded from sram_dout and the matured tag.
  - Read latency is 2 cycles; rdata is glitch-free.
  - Reset clears rvalid and the rdata registers (to 0).
- Not defined:
  - p_rdata is wired combinationally to sram_dout for both ports, and p_rvalid comes straight from the tag register.
  - Read latency is 1 cycle.

## Test plan

- After reset, A writes 0xDEADBEEF_CAFEF00D to addr 5 with wmask=2'b11, then B reads addr 5 → b_rvalid exactly 1 cycle later (2 with the macro) with that value; a_rvalid stays 0.
- Masked write: A writes 0x1111…1111 to addr 7 with wmask=2'b01, then A reads addr 7 → upper 32 bits 0, lower 32 bits 0x11111111.
- Both ports valid continuously with reads of distinct addresses for 8 cycles → grants alternate A,B,A,B… starting with A; rvalid alternates in the same order with correct data.
- A asserts lock with 20 back-to-back writes, MAX_LOCK=16, B valid throughout → A is granted 16 consecutive cycles, then B is granted the next cycle.
- A locks, then holds valid=0, lock=1 for 3 cycles → no grants to B and sram_we=0 during those cycles; A releasing lock → B is granted the next cycle.
- A read is accepted in cycle T and rst is asserted in cycle T+1 → no a_rvalid ever appears for it; after reset, state is IDLE and prio=A.
